// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush scheduler for the 5-stage MIPS pipeline (multiply hold, load-use bubble, branch flush).
// Defining STALL_PERF_EN adds the saturating StallCycles counter output.
module pipe_stall_ctrl #(
    parameter int MUL_LAT      = 4,
    parameter int BR_FLUSH_CYC = 2
`ifdef STALL_PERF_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [1:0]       Branch,
    input  logic             IDEXMemRead,
    input  logic [4:0]       IDEXRt,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             IDEXMulOp,
`ifdef STALL_PERF_EN
    output logic [CNT_W-1:0] StallCycles,
`endif
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             MulGo,
    output logic             MulBusy
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MUL_WAIT = 2'd1;
    localparam logic [1:0] ST_BR_FLUSH = 2'd2;

    // MulGo cycle counts as the first stall cycle, so the wait state covers MUL_LAT-1 cycles.
    localparam logic [3:0] MUL_RELOAD = 4'(MUL_LAT - 2);
    localparam logic [1:0] BR_RELOAD  = (BR_FLUSH_CYC > 1) ? 2'(BR_FLUSH_CYC - 2) : 2'd0;

    logic [1:0] state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic [1:0] br_cnt_q, br_cnt_d;
    logic       mul_ack_q, mul_ack_d;

    logic load_use;
    logic mul_start;
    logic br_taken;

    assign load_use  = IDEXMemRead && (IDEXRt != 5'd0) &&
                       ((IDEXRt == IFIDRs) || (IDEXRt == IFIDRt));
    assign mul_start = IDEXMulOp && !mul_ack_q;
    assign br_taken  = (Branch != 2'b00);

    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        br_cnt_d   = br_cnt_q;
        mul_ack_d  = mul_ack_q;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        MulGo      = 1'b0;
        MulBusy    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mul_start) begin
                    MulGo      = 1'b1;
                    MulBusy    = 1'b1;
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXWrite  = 1'b0;
                    EXMEMFlush = 1'b1;
                    state_d    = ST_MUL_WAIT;
                    mul_cnt_d  = MUL_RELOAD;
                end else begin
                    mul_ack_d = 1'b0;
                    if (load_use) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                    end else if (br_taken) begin
                        IFIDFlush = 1'b1;
                        if (BR_FLUSH_CYC > 1) begin
                            state_d  = ST_BR_FLUSH;
                            br_cnt_d = BR_RELOAD;
                        end
                    end
                end
            end

            ST_MUL_WAIT: begin
                MulBusy    = 1'b1;
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                EXMEMFlush = 1'b1;
                if (mul_cnt_q == 4'd0) begin
                    state_d   = ST_RUN;
                    mul_ack_d = 1'b1;
                end else begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                end
            end

            ST_BR_FLUSH: begin
                // A new multiply wins over the remaining wrong-path flush cycles.
                if (mul_start) begin
                    MulGo      = 1'b1;
                    MulBusy    = 1'b1;
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXWrite  = 1'b0;
                    EXMEMFlush = 1'b1;
                    state_d    = ST_MUL_WAIT;
                    mul_cnt_d  = MUL_RELOAD;
                    br_cnt_d   = 2'd0;
                end else begin
                    IFIDFlush = 1'b1;
                    if (br_taken) begin
                        br_cnt_d = BR_RELOAD;
                    end else if (br_cnt_q == 2'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        br_cnt_d = br_cnt_q - 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // While reset is asserted the pipeline runs freely regardless of the inputs.
        if (!Rst_n) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IDEXWrite  = 1'b1;
            IFIDFlush  = 1'b0;
            IDEXFlush  = 1'b0;
            EXMEMFlush = 1'b0;
            MulGo      = 1'b0;
            MulBusy    = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_RUN;
            mul_cnt_q <= 4'd0;
            br_cnt_q  <= 2'd0;
            mul_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            br_cnt_q  <= br_cnt_d;
            mul_ack_q <= mul_ack_d;
        end
    end

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl (MUL_LAT=4, BR_FLUSH_CYC=2; STALL_PERF_EN uses CNT_W=4).
module tb_pipe_stall_ctrl;

    // {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MulGo, MulBusy}
    localparam logic [7:0] NORM  = 8'b1110_0000;
    localparam logic [7:0] LU    = 8'b0010_1000;
    localparam logic [7:0] BRF   = 8'b1111_0000;
    localparam logic [7:0] MGO   = 8'b0000_0111;
    localparam logic [7:0] MWAIT = 8'b0000_0101;

    logic       Clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       Rst_n = 1'b0;
    logic [1:0] Branch = 2'b00;
    logic       IDEXMemRead = 1'b0;
    logic [4:0] IDEXRt = 5'd0;
    logic [4:0] IFIDRs = 5'd0;
    logic [4:0] IFIDRt = 5'd0;
    logic       IDEXMulOp = 1'b0;
    logic       PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MulGo, MulBusy;
`ifdef STALL_PERF_EN
    logic [3:0] StallCycles;
`endif

    logic [7:0] obs;
    assign obs = {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MulGo, MulBusy};

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic       prev_go = 1'b0;

    pipe_stall_ctrl #(
        .MUL_LAT(4),
        .BR_FLUSH_CYC(2)
`ifdef STALL_PERF_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Branch(Branch),
        .IDEXMemRead(IDEXMemRead),
        .IDEXRt(IDEXRt),
        .IFIDRs(IFIDRs),
        .IFIDRt(IFIDRt),
        .IDEXMulOp(IDEXMulOp),
`ifdef STALL_PERF_EN
        .StallCycles(StallCycles),
`endif
        .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite),
        .IDEXWrite(IDEXWrite),
        .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush),
        .EXMEMFlush(EXMEMFlush),
        .MulGo(MulGo),
        .MulBusy(MulBusy)
    );

    always begin
        #5;
        if (clk_en) Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [1:0] br, input logic mr, input logic [4:0] ex_rt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic mul, input logic [7:0] exp);
        @(negedge Clk);
        Branch      = br;
        IDEXMemRead = mr;
        IDEXRt      = ex_rt;
        IFIDRs      = rs;
        IFIDRt      = rt;
        IDEXMulOp   = mul;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    always begin
        @(negedge Clk);
        #2;
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), {24'd0, obs}, {24'd0, exp_q.pop_front()});
        end
        if (Rst_n) begin
            check("mulgo_twice", {31'd0, prev_go & MulGo}, 32'd0);
        end
        prev_go = MulGo;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_init", {24'd0, obs}, {24'd0, NORM});
        @(negedge Clk);
        Rst_n = 1'b1;

        cyc("idle0",    0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);
        cyc("lu_rs",    0, 1, 5'd8, 5'd8, 5'd0, 0, LU);
        cyc("lu_after", 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);
        cyc("lu_zero",  0, 1, 5'd0, 5'd0, 5'd0, 0, NORM);
        cyc("lu_rt",    0, 1, 5'd9, 5'd3, 5'd9, 0, LU);
        cyc("lu_norda", 0, 0, 5'd9, 5'd9, 5'd9, 0, NORM);

        cyc("mul0",     0, 0, 5'd0, 5'd0, 5'd0, 1, MGO);
        cyc("mul1",     0, 0, 5'd0, 5'd0, 5'd0, 1, MWAIT);
        cyc("mul2",     0, 0, 5'd0, 5'd0, 5'd0, 1, MWAIT);
        cyc("mul3",     0, 0, 5'd0, 5'd0, 5'd0, 1, MWAIT);
        cyc("mul4_ack", 0, 0, 5'd0, 5'd0, 5'd0, 1, NORM);
        cyc("mul5_new", 0, 0, 5'd0, 5'd0, 5'd0, 1, MGO);
        cyc("mul6",     1, 1, 5'd8, 5'd8, 5'd0, 1, MWAIT);
        cyc("mul7",     0, 0, 5'd0, 5'd0, 5'd0, 1, MWAIT);
        cyc("mul8",     0, 0, 5'd0, 5'd0, 5'd0, 1, MWAIT);
        cyc("mul9",     0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);

        cyc("br0",      1, 0, 5'd0, 5'd0, 5'd0, 0, BRF);
        cyc("br1",      0, 0, 5'd0, 5'd0, 5'd0, 0, BRF);
        cyc("br2",      0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);
        cyc("bre0",     1, 0, 5'd0, 5'd0, 5'd0, 0, BRF);
        cyc("bre1",     2, 0, 5'd0, 5'd0, 5'd0, 0, BRF);
        cyc("bre2",     0, 0, 5'd0, 5'd0, 5'd0, 0, BRF);
        cyc("bre3",     0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);

        cyc("col_lu",   1, 1, 5'd8, 5'd8, 5'd0, 0, LU);
        cyc("col_next", 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);

        cyc("pre0",     1, 0, 5'd0, 5'd0, 5'd0, 0, BRF);
        cyc("pre1_go",  0, 0, 5'd0, 5'd0, 5'd0, 1, MGO);
        cyc("pre2",     0, 0, 5'd0, 5'd0, 5'd0, 1, MWAIT);
        cyc("pre3",     0, 0, 5'd0, 5'd0, 5'd0, 1, MWAIT);
        cyc("pre4",     0, 0, 5'd0, 5'd0, 5'd0, 1, MWAIT);
        cyc("pre5",     0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);
        cyc("pre6",     0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);

        cyc("rst_mul0", 0, 0, 5'd0, 5'd0, 5'd0, 1, MGO);
        cyc("rst_mul1", 0, 0, 5'd0, 5'd0, 5'd0, 1, MWAIT);
        #3;
        clk_en = 1'b0;
        Rst_n  = 1'b0;
        #1;
        check("rst_async", {24'd0, obs}, {24'd0, NORM});
        IDEXMulOp = 1'b0;
        #1;
        Rst_n = 1'b1;
        #1;
        check("rst_release", {24'd0, obs}, {24'd0, NORM});
        clk_en = 1'b1;
        cyc("post_rst0", 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);
        cyc("post_rst1", 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);
        cyc("post_br0",  1, 0, 5'd0, 5'd0, 5'd0, 0, BRF);
        cyc("post_br1",  0, 0, 5'd0, 5'd0, 5'd0, 0, BRF);
        cyc("post_br2",  0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);

`ifdef STALL_PERF_EN
        @(negedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        check("perf_rst0", {28'd0, StallCycles}, 32'd0);
        Rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc("perf_lu", 0, 1, 5'd8, 5'd8, 5'd0, 0, LU);
        end
        cyc("perf_idle", 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM);
        #3;
        check("perf_sat", {28'd0, StallCycles}, 32'd15);
        Rst_n = 1'b0;
        #1;
        check("perf_clr", {28'd0, StallCycles}, 32'd0);
        Rst_n = 1'b1;
`endif

        @(negedge Clk);
        #3;
        check("sb_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
